// File: rtl/oc8051_ifetch.sv
// Instruction fetch unit for an 8051-class core: issues a ROM address, captures the
// three-byte window the ROM returns, and presents it to the decoder until acknowledged.
module oc8051_ifetch #(
    parameter logic [15:0] RST_VECTOR = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] rom_addr,
    input  logic        rom_ea_int,
    input  logic [7:0]  rom_data1,
    input  logic [7:0]  rom_data2,
    input  logic [7:0]  rom_data3,
    output logic [7:0]  op1,
    output logic [7:0]  op2,
    output logic [7:0]  op3,
    output logic [15:0] op_pc,
    output logic        op_valid,
    input  logic        op_ack,
    input  logic [1:0]  op_len,
    input  logic        jmp,
    input  logic [15:0] jmp_addr,
    output logic        fault
);

    typedef enum logic [1:0] {
        ST_ISSUE,
        ST_WAIT,
        ST_VALID,
        ST_FAULT
    } state_t;

    state_t      state, state_nxt;
    logic [15:0] rom_addr_nxt;
    logic [15:0] op_pc_nxt;
    logic [7:0]  op1_nxt, op2_nxt, op3_nxt;
    logic        op_valid_nxt;
    logic        fault_nxt;
    logic [15:0] step_len;

    // A zero length from the decoder still advances by one byte so fetch never stalls.
    assign step_len = (op_len == 2'd0) ? 16'd1 : {14'd0, op_len};

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        state_nxt    = state;
        rom_addr_nxt = rom_addr;
        op_pc_nxt    = op_pc;
        op1_nxt      = op1;
        op2_nxt      = op2;
        op3_nxt      = op3;
        op_valid_nxt = op_valid;
        fault_nxt    = fault;

        if (jmp) begin
            // Redirect wins over everything; whatever the ROM returns next is dropped
            // because ISSUE never captures data.
            rom_addr_nxt = jmp_addr;
            op_valid_nxt = 1'b0;
            fault_nxt    = 1'b0;
            state_nxt    = ST_ISSUE;
        end else begin
            unique case (state)
                ST_ISSUE: begin
                    if (rom_ea_int) begin
                        state_nxt = ST_WAIT;
                    end else begin
                        fault_nxt = 1'b1;
                        state_nxt = ST_FAULT;
                    end
                end
                ST_WAIT: begin
                    op1_nxt      = rom_data1;
                    op2_nxt      = rom_data2;
                    op3_nxt      = rom_data3;
                    op_pc_nxt    = rom_addr;
                    op_valid_nxt = 1'b1;
                    state_nxt    = ST_VALID;
                end
                ST_VALID: begin
                    if (op_ack) begin
                        rom_addr_nxt = op_pc + step_len;
                        op_valid_nxt = 1'b0;
                        state_nxt    = ST_ISSUE;
                    end
                end
                ST_FAULT: begin
                    fault_nxt    = 1'b1;
                    op_valid_nxt = 1'b0;
                end
                default: state_nxt = ST_ISSUE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!rst) begin
            state    <= ST_ISSUE;
            rom_addr <= RST_VECTOR;
            op_pc    <= RST_VECTOR;
            op1      <= 8'h00;
            op2      <= 8'h00;
            op3      <= 8'h00;
            op_valid <= 1'b0;
            fault    <= 1'b0;
        end else begin
            state    <= state_nxt;
            rom_addr <= rom_addr_nxt;
            op_pc    <= op_pc_nxt;
            op1      <= op1_nxt;
            op2      <= op2_nxt;
            op3      <= op3_nxt;
            op_valid <= op_valid_nxt;
            fault    <= fault_nxt;
        end
    end

endmodule

// File: tb/tb_oc8051_ifetch.sv
// Directed bench for oc8051_ifetch with a registered ROM model; 0x8000-0x8FFF is external.
module tb_oc8051_ifetch;

    logic        clk;
    logic        rst;
    logic [15:0] rom_addr;
    logic        rom_ea_int;
    logic [7:0]  rom_data1, rom_data2, rom_data3;
    logic [7:0]  op1, op2, op3;
    logic [15:0] op_pc;
    logic        op_valid;
    logic        op_ack;
    logic [1:0]  op_len;
    logic        jmp;
    logic [15:0] jmp_addr;
    logic        fault;

    int checks = 0;
    int errors = 0;

    logic [7:0]  mem [0:65535];
    logic [15:0] addr_p1, addr_p2;

    oc8051_ifetch #(.RST_VECTOR(16'h0000)) dut (
        .clk       (clk),
        .rst       (rst),
        .rom_addr  (rom_addr),
        .rom_ea_int(rom_ea_int),
        .rom_data1 (rom_data1),
        .rom_data2 (rom_data2),
        .rom_data3 (rom_data3),
        .op1       (op1),
        .op2       (op2),
        .op3       (op3),
        .op_pc     (op_pc),
        .op_valid  (op_valid),
        .op_ack    (op_ack),
        .op_len    (op_len),
        .jmp       (jmp),
        .jmp_addr  (jmp_addr),
        .fault     (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign addr_p1    = rom_addr + 16'd1;
    assign addr_p2    = rom_addr + 16'd2;
    assign rom_ea_int = (rom_addr[15:12] != 4'h8);

    always @(posedge clk) begin
        rom_data1 <= mem[rom_addr];
        rom_data2 <= mem[addr_p1];
        rom_data3 <= mem[addr_p2];
    end

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_jmp(input logic [15:0] target);
        jmp      = 1'b1;
        jmp_addr = target;
        step();
        jmp      = 1'b0;
    endtask

    task automatic do_ack(input logic [1:0] len);
        op_ack = 1'b1;
        op_len = len;
        step();
        op_ack = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'hFF;
        mem[16'h0000] = 8'h02; mem[16'h0001] = 8'h00; mem[16'h0002] = 8'h30;
        mem[16'h0003] = 8'hE4; mem[16'h0004] = 8'hF5; mem[16'h0005] = 8'h90;
        mem[16'h0010] = 8'h00; mem[16'h0011] = 8'hA1; mem[16'h0012] = 8'hB2;
        mem[16'h0013] = 8'hC4;
        mem[16'h0040] = 8'hC3; mem[16'h0041] = 8'h22;
        mem[16'h0100] = 8'h75; mem[16'h0101] = 8'h81; mem[16'h0102] = 8'h07;
        mem[16'h0200] = 8'hAA; mem[16'h0201] = 8'hBB; mem[16'h0202] = 8'hCC;
        mem[16'hFFFE] = 8'h11; mem[16'hFFFF] = 8'h22;

        rst = 1'b0; op_ack = 1'b0; op_len = 2'd0; jmp = 1'b0; jmp_addr = 16'h0000;

        // Reset state while the clock runs
        step(); step();
        check("rst_rom_addr", 32'(rom_addr), 32'h0000);
        check("rst_op_valid", 32'(op_valid), 32'h0);
        check("rst_fault",    32'(fault),    32'h0);
        check("rst_op_pc",    32'(op_pc),    32'h0000);
        check("rst_op1",      32'(op1),      32'h00);

        // First fetch from the reset vector
        rst = 1'b1;
        step();
        check("boot_e1_valid", 32'(op_valid), 32'h0);
        step();
        check("boot_valid", 32'(op_valid), 32'h1);
        check("boot_ops",   {8'h00, op1, op2, op3}, 32'h00020030);
        check("boot_pc",    32'(op_pc),    32'h0000);
        check("boot_addr",  32'(rom_addr), 32'h0000);

        // Hold without ack
        for (int i = 0; i < 5; i++) begin
            step();
            check("hold_state", {op_valid, 7'd0, op1, op2, op3}, {1'b1, 7'd0, 24'h020030});
            check("hold_pc",    32'(op_pc), 32'h0000);
        end

        // Ack a 3-byte instruction
        do_ack(2'd3);
        check("ack3_addr",  32'(rom_addr), 32'h0003);
        check("ack3_valid", 32'(op_valid), 32'h0);
        step();
        check("ack3_wait_valid", 32'(op_valid), 32'h0);
        step();
        check("ack3_ops", {8'h00, op1, op2, op3}, 32'h00E4F590);
        check("ack3_pc",  32'(op_pc), 32'h0003);

        // op_len=0 advances by one
        do_jmp(16'h0010);
        step(); step();
        check("j10_pc", 32'(op_pc), 32'h0010);
        do_ack(2'd0);
        check("len0_addr", 32'(rom_addr), 32'h0011);
        step(); step();
        check("len0_pc",  32'(op_pc), 32'h0011);
        check("len0_op1", 32'(op1),   32'hA1);

        // jmp and ack together: jmp wins
        jmp = 1'b1; jmp_addr = 16'h0100; op_ack = 1'b1; op_len = 2'd2;
        step();
        jmp = 1'b0; op_ack = 1'b0;
        check("jmpack_addr", 32'(rom_addr), 32'h0100);
        step(); step();
        check("jmpack_pc",  32'(op_pc), 32'h0100);
        check("jmpack_ops", {8'h00, op1, op2, op3}, 32'h00758107);

        // External address faults; ack is ignored there
        do_jmp(16'h8000);
        step();
        check("fault_set",   32'(fault),    32'h1);
        check("fault_valid", 32'(op_valid), 32'h0);
        op_ack = 1'b1; op_len = 2'd1;
        step(); step();
        op_ack = 1'b0;
        check("fault_hold",      32'(fault),    32'h1);
        check("fault_ack_addr",  32'(rom_addr), 32'h8000);
        check("fault_ack_valid", 32'(op_valid), 32'h0);
        do_jmp(16'h0040);
        check("fault_clear", 32'(fault), 32'h0);
        step(); step();
        check("recover_pc",    32'(op_pc),    32'h0040);
        check("recover_valid", 32'(op_valid), 32'h1);
        check("recover_op1",   32'(op1),      32'hC3);

        // Address wrap at the top of memory
        do_jmp(16'hFFFE);
        step(); step();
        check("wrap_pc",  32'(op_pc), 32'hFFFE);
        check("wrap_ops", {8'h00, op1, op2, op3}, 32'h00112202);
        do_ack(2'd2);
        check("wrap_addr", 32'(rom_addr), 32'h0000);

        // Reset pulsed mid-fetch aborts the pending capture
        do_jmp(16'h0200);
        step();
        #2 rst = 1'b0;
        #1;
        check("arst_valid", 32'(op_valid), 32'h0);
        check("arst_addr",  32'(rom_addr), 32'h0000);
        check("arst_op1",   32'(op1),      32'h00);
        step();
        rst = 1'b1;
        step();
        check("post_rst_e1_valid", 32'(op_valid), 32'h0);
        step();
        check("post_rst_valid", 32'(op_valid), 32'h1);
        check("post_rst_pc",    32'(op_pc),    32'h0000);
        check("post_rst_ops",   {8'h00, op1, op2, op3}, 32'h00020030);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
